// File: rtl/fetch_pkg.sv
// Shared types and constants for the s1_fetch instruction queue.
package fetch_pkg;

    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            filled;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue between the program counter and decode.
// Define FETCHQ_BYPASS_EN to forward a response straight to decode when it fills the head entry.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 4,
    parameter logic [ILEN-1:0] RST_INSTR = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [ILEN-1:0] pc_in,
    output logic            pc_inc,
    output logic            pc_stll,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [ILEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [ILEN-1:0] rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [ILEN-1:0] dec_instr,
    output logic [ILEN-1:0] dec_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = $clog2(MAX_OUTST + 1);

    logic [PW-1:0]   alloc_ptr, fill_ptr, head_ptr;
    logic [PW-1:0]   used, unfilled;
    logic [DW-1:0]   drop_cnt, drop_flush;
    logic [31:0]     drop_sum;
    logic [DEPTH-1:0] filled;
    logic [ILEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];
    logic [AW-1:0]   alloc_idx, fill_idx, head_idx;
    fq_entry_t       head_entry;

    logic full, outst_ok, req_fire;
    logic rsp_drop, rsp_fill, byp_hit, pop;

    assign used      = alloc_ptr - head_ptr;
    assign unfilled  = alloc_ptr - fill_ptr;
    assign alloc_idx = alloc_ptr[AW-1:0];
    assign fill_idx  = fill_ptr[AW-1:0];
    assign head_idx  = head_ptr[AW-1:0];

    // Stale responses still owed by memory count against the outstanding limit.
    assign full     = (used == PW'(DEPTH));
    assign outst_ok = (32'(unfilled) + 32'(drop_cnt)) < 32'(MAX_OUTST);

    assign req_valid = rst_n && !flush && !full && outst_ok;
    assign req_addr  = pc_in;
    assign req_fire  = req_valid && req_ready;
    assign pc_inc    = req_fire;
    assign pc_stll   = !rst_n || (!pc_inc && !flush);

    assign rsp_drop = rsp_valid && !flush && (drop_cnt != '0);
    assign rsp_fill = rsp_valid && !flush && (drop_cnt == '0) && (unfilled != '0);

`ifdef FETCHQ_BYPASS_EN
    assign byp_hit = rsp_fill && (fill_ptr == head_ptr) && (used != '0);
`else
    assign byp_hit = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        head_entry.pc     = pc_mem[head_idx];
        head_entry.instr  = instr_mem[head_idx];
        head_entry.filled = filled[head_idx];
        if (byp_hit) begin
            head_entry.instr = rsp_data;
        end
    end

    assign dec_valid = rst_n && !flush && (used != '0) && (head_entry.filled || byp_hit);
    assign dec_instr = rst_n ? head_entry.instr : RST_INSTR;
    assign dec_pc    = rst_n ? head_entry.pc : '0;
    assign pop       = dec_valid && dec_ready;

    // On redirect every unfilled slot becomes a response to drop; a same-cycle response is already stale.
    always_comb begin
        drop_sum = 32'(drop_cnt) + 32'(unfilled);
        if (rsp_valid && (drop_sum != '0)) begin
            drop_sum = drop_sum - 32'd1;
        end
        drop_flush = DW'(drop_sum);
    end

    // NOTE: sequential state uses non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= '0;
            filled    <= '0;
        end else if (flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= drop_flush;
            filled    <= '0;
        end else begin
            if (req_fire) begin
                alloc_ptr          <= alloc_ptr + PW'(1);
                filled[alloc_idx]  <= 1'b0;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - DW'(1);
            end
            if (rsp_fill) begin
                fill_ptr          <= fill_ptr + PW'(1);
                filled[fill_idx]  <= 1'b1;
            end
            // A bypassed entry is popped in its fill cycle; this later clear wins over the set above.
            if (pop) begin
                head_ptr          <= head_ptr + PW'(1);
                filled[head_idx]  <= 1'b0;
            end
        end
    end

    // NOTE: payload storage is not reset; the filled bits and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_mem[alloc_idx] <= pc_in;
        end
        if (rsp_fill) begin
            instr_mem[fill_idx] <= rsp_data;
        end
    end

`ifndef SYNTHESIS
    rsp_without_request : assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !flush) |-> ((drop_cnt != '0) || (unfilled != '0)));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a program-counter model and an in-order instruction memory.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic [31:0] pc_q, flush_target;
    logic        pc_inc, pc_stll;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_instr, dec_pc;
    logic        rsp_en;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_q[$];

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .pc_in     (pc_q),
        .pc_inc    (pc_inc),
        .pc_stll   (pc_stll),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_instr (dec_instr),
        .dec_pc    (dec_pc)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return 32'hAAAA_0000 + ((addr - 32'h8000_0000) >> 2);
    endfunction

    // Program counter: load on redirect, else advance on inc.
    always @(posedge clk) begin
        if (!rst_n)      pc_q <= 32'h8000_0000;
        else if (flush)  pc_q <= flush_target;
        else if (pc_inc) pc_q <= pc_q + 32'd4;
    end

    // In-order memory: a request is answered no earlier than the next edge, when rsp_en allows.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_q.delete();
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (rsp_en && mem_q.size() != 0) begin
                rsp_valid <= 1'b1;
                rsp_data  <= mem_q.pop_front();
            end else begin
                rsp_valid <= 1'b0;
            end
            if (req_valid && req_ready) mem_q.push_back(instr_of(req_addr));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b0; flush_target = '0;
        req_ready = 1'b0; dec_ready = 1'b0; rsp_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; flush_target = '0;
        req_ready = 1'b0; dec_ready = 1'b0; rsp_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rst_dec_valid: got %b want 0", dec_valid); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
        checks++; if (pc_inc !== 1'b0) begin errors++; $display("FAIL rst_pc_inc: got %b want 0", pc_inc); end
        checks++; if (pc_stll !== 1'b1) begin errors++; $display("FAIL rst_pc_stll: got %b want 1", pc_stll); end
        checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL rst_dec_pc: got %h want 0", dec_pc); end
        checks++; if (dec_instr !== 32'h0000_0013) begin errors++; $display("FAIL rst_dec_instr: got %h want 00000013", dec_instr); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL post_rst_req_valid: got %b want 1", req_valid); end
        checks++; if (req_addr !== 32'h8000_0000) begin errors++; $display("FAIL post_rst_req_addr: got %h want 80000000", req_addr); end
        checks++; if (pc_stll !== 1'b1) begin errors++; $display("FAIL post_rst_stall_no_ready: got %b want 1", pc_stll); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        int pops, gaps;
        bit started;
        do_reset();
        req_ready = 1'b1; rsp_en = 1'b1; dec_ready = 1'b1;
        exp_pc = 32'h8000_0000; pops = 0; gaps = 0; started = 1'b0;
        for (int i = 0; i < 40 && pops < 12; i++) begin
            #1;
            if (dec_valid && dec_ready) begin
                checks++; if (dec_pc !== exp_pc) begin errors++; $display("FAIL stream_pc: got %h want %h", dec_pc, exp_pc); end
                checks++; if (dec_instr !== instr_of(exp_pc)) begin errors++; $display("FAIL stream_instr: got %h want %h", dec_instr, instr_of(exp_pc)); end
                exp_pc += 32'd4; pops++; started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            @(negedge clk);
        end
        checks++; if (pops != 12) begin errors++; $display("FAIL stream_pops: got %0d want 12", pops); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL stream_throughput_gaps: got %0d want 0", gaps); end
    endtask

    task automatic test_full();
        logic [31:0] exp_pc;
        int incs, pops;
        do_reset();
        req_ready = 1'b1; rsp_en = 1'b1; dec_ready = 1'b0;
        incs = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (pc_inc) incs++;
            @(negedge clk);
        end
        #1;
        checks++; if (incs != 4) begin errors++; $display("FAIL full_req_count: got %0d want 4", incs); end
        checks++; if (pc_stll !== 1'b1) begin errors++; $display("FAIL full_pc_stll: got %b want 1", pc_stll); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL full_req_valid: got %b want 0", req_valid); end
        dec_ready = 1'b1;
        exp_pc = 32'h8000_0000; pops = 0;
        for (int i = 0; i < 40 && pops < 8; i++) begin
            #1;
            if (dec_valid && dec_ready) begin
                checks++; if (dec_pc !== exp_pc) begin errors++; $display("FAIL full_drain_pc: got %h want %h", dec_pc, exp_pc); end
                checks++; if (dec_instr !== instr_of(exp_pc)) begin errors++; $display("FAIL full_drain_instr: got %h want %h", dec_instr, instr_of(exp_pc)); end
                exp_pc += 32'd4; pops++;
            end
            @(negedge clk);
        end
        checks++; if (pops != 8) begin errors++; $display("FAIL full_drain_pops: got %0d want 8", pops); end
    endtask

    task automatic test_flush_outstanding();
        logic [31:0] exp_pc;
        int incs, pops;
        do_reset();
        req_ready = 1'b1; rsp_en = 1'b0; dec_ready = 1'b1;
        incs = 0;
        for (int i = 0; i < 20 && incs < 3; i++) begin
            #1;
            if (pc_inc) incs++;
            @(negedge clk);
        end
        flush = 1'b1; flush_target = 32'h8000_0100;
        #1;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL flush3_dec_valid: got %b want 0", dec_valid); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL flush3_req_valid: got %b want 0", req_valid); end
        checks++; if (pc_stll !== 1'b0) begin errors++; $display("FAIL flush3_pc_stll: got %b want 0", pc_stll); end
        @(negedge clk);
        flush = 1'b0; rsp_en = 1'b1;
        exp_pc = 32'h8000_0100; pops = 0;
        for (int i = 0; i < 60 && pops < 6; i++) begin
            #1;
            if (dec_valid && dec_ready) begin
                checks++; if (dec_pc !== exp_pc) begin errors++; $display("FAIL flush3_pc: got %h want %h", dec_pc, exp_pc); end
                checks++; if (dec_instr !== instr_of(exp_pc)) begin errors++; $display("FAIL flush3_instr: got %h want %h", dec_instr, instr_of(exp_pc)); end
                exp_pc += 32'd4; pops++;
            end
            @(negedge clk);
        end
        checks++; if (pops != 6) begin errors++; $display("FAIL flush3_pops: got %0d want 6", pops); end
    endtask

    task automatic test_flush_with_rsp();
        logic [31:0] exp_pc;
        int pops;
        do_reset();
        req_ready = 1'b1; rsp_en = 1'b0; dec_ready = 1'b1;
        #1;
        checks++; if (pc_inc !== 1'b1) begin errors++; $display("FAIL flushrsp_first_req: got %b want 1", pc_inc); end
        @(negedge clk);
        req_ready = 1'b0;
        repeat (2) @(negedge clk);
        rsp_en = 1'b1;
        @(negedge clk);
        rsp_en = 1'b0; flush = 1'b1; flush_target = 32'h8000_0200;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL flushrsp_setup_rsp: got %b want 1", rsp_valid); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL flushrsp_dec_valid: got %b want 0", dec_valid); end
        @(negedge clk);
        flush = 1'b0; req_ready = 1'b1; rsp_en = 1'b1;
        exp_pc = 32'h8000_0200; pops = 0;
        for (int i = 0; i < 40 && pops < 4; i++) begin
            #1;
            if (dec_valid && dec_ready) begin
                checks++; if (dec_pc !== exp_pc) begin errors++; $display("FAIL flushrsp_pc: got %h want %h", dec_pc, exp_pc); end
                checks++; if (dec_instr !== instr_of(exp_pc)) begin errors++; $display("FAIL flushrsp_instr: got %h want %h", dec_instr, instr_of(exp_pc)); end
                exp_pc += 32'd4; pops++;
            end
            @(negedge clk);
        end
        checks++; if (pops != 4) begin errors++; $display("FAIL flushrsp_pops: got %0d want 4", pops); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc, exp_addr;
        int incs, pops;
        do_reset();
        rsp_en = 1'b1;
        exp_pc = 32'h8000_0000; exp_addr = 32'h8000_0000; incs = 0; pops = 0;
        for (int i = 0; i < 80; i++) begin
            req_ready = (i < 60) && ((i % 2) == 0);
            dec_ready = (i < 60) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (pc_inc) begin
                checks++; if (req_addr !== exp_addr) begin errors++; $display("FAIL b2b_req_addr: got %h want %h", req_addr, exp_addr); end
                exp_addr += 32'd4; incs++;
            end
            if (dec_valid && dec_ready) begin
                checks++; if (dec_pc !== exp_pc) begin errors++; $display("FAIL b2b_pc: got %h want %h", dec_pc, exp_pc); end
                checks++; if (dec_instr !== instr_of(exp_pc)) begin errors++; $display("FAIL b2b_instr: got %h want %h", dec_instr, instr_of(exp_pc)); end
                exp_pc += 32'd4; pops++;
            end
            @(negedge clk);
        end
        checks++; if (incs != pops) begin errors++; $display("FAIL b2b_inc_vs_pops: got incs=%0d pops=%0d", incs, pops); end
        checks++; if (incs < 10) begin errors++; $display("FAIL b2b_progress: got %0d want >=10", incs); end
    endtask

    task automatic test_reset_midfetch();
        bit seen;
        do_reset();
        req_ready = 1'b1; rsp_en = 1'b1; dec_ready = 1'b0;
        repeat (2) begin #1; @(negedge clk); end
        req_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (dec_valid) seen = 1'b1;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL midrst_setup_valid: got %b want 1", dec_valid); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL midrst_dec_valid: got %b want 0", dec_valid); end
        checks++; if (dec_instr !== 32'h0000_0013) begin errors++; $display("FAIL midrst_dec_instr: got %h want 00000013", dec_instr); end
        checks++; if (pc_stll !== 1'b1) begin errors++; $display("FAIL midrst_pc_stll: got %b want 1", pc_stll); end
        checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL midrst_dec_pc: got %h want 0", dec_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL midrst_after_valid: got %b want 0", dec_valid); end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; flush_target = '0;
        req_ready = 1'b0; dec_ready = 1'b0; rsp_en = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_flush_outstanding();
        test_flush_with_rsp();
        test_back_to_back();
        test_reset_midfetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue for s1_fetch, directly downstream of the program counter.
- Issues in-order instruction-memory requests at the current PC and drives the PC's inc/stll.
- Buffers {pc, instr} pairs until decode accepts them.
- On a redirect (flush), discards queued entries and drops stale in-flight responses, so decode sees only post-redirect instructions.

Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥2
- MAX_OUTST, 4, maximum unfilled plus to-be-dropped memory responses; ≥1
- RST_INSTR, 32'h0000_0013, dec_instr value during reset (NOP)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  redirect; same cycle the PC asserts ld
- pc_in  in  32  current PC from program counter
- pc_inc  out  1  PC advance strobe (program counter inc)
- pc_stll  out  1  PC hold (program counter stll)
- req_valid  out  1  imem request valid
- req_ready  in  1  imem accepts request
- req_addr  out  32  imem request address
- rsp_valid  in  1  imem response valid; in order, ≥1 cycle after its request
- rsp_data  in  32  imem response word
- dec_valid  out  1  instruction available to decode
- dec_ready  in  1  decode accepts
- dec_instr  out  32  head instruction
- dec_pc  out  32  head PC

Behaviour:
- Storage per entry: pc[31:0], instr[31:0], filled bit.
- Pointers: alloc_ptr, fill_ptr, head_ptr, each log2(DEPTH)+1 bits with a wrap bit. Counters: used = alloc_ptr−head_ptr; unfilled = alloc_ptr−fill_ptr; drop_cnt.
- Request: req_valid = !flush && used<DEPTH && (unfilled+drop_cnt)<MAX_OUTST.
  - req_addr = pc_in.
  - On req_valid&&req_ready: write pc_in at alloc_ptr, clear its filled bit, advance alloc_ptr.
- PC control: pc_inc = req_valid&&req_ready; pc_stll = !pc_inc && !flush.
- Response:
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise: write rsp_data at fill_ptr, set filled, advance fill_ptr.
  - A response with unfilled==0 and drop_cnt==0 is a protocol error; ignore it, and an assertion fires in simulation.
- Decode side: dec_valid = used>0 && filled[head_ptr]. dec_instr/dec_pc come from the head entry. On dec_valid&&dec_ready, clear filled and advance head_ptr.
- Latency: a response registered at cycle N is presented as dec_valid at N+1. Full throughput is 1 instr/cycle with a 1-cycle memory.
- Simultaneous alloc/fill/pop in one cycle: all three apply.
- Full: used==DEPTH → req_valid=0, pc_stll=1. The PC is never advanced without a slot reserved.
- Flush (highest priority, registered):
  - alloc/fill/head pointers reset to 0; all filled bits cleared.
  - drop_cnt ← drop_cnt + unfilled − (rsp_valid ? 1 : 0). A same-cycle response is treated as stale and discarded.
  - No request or pop completes in the flush cycle; dec_valid is forced to 0 in that cycle.
  - Cycle after flush: req_valid may assert at the new pc_in.
- Flush with drop_cnt>0: new requests are allowed while (unfilled+drop_cnt)<MAX_OUTST. In-order return guarantees the stale responses arrive first.
- Reset (any cycle, including mid-fetch):
  - Pointers, drop_cnt and filled bits go to 0.
  - Outputs: dec_valid=0, req_valid=0, pc_inc=0, pc_stll=1, dec_pc=0, dec_instr=RST_INSTR.
  - Responses outstanding at reset are the memory's responsibility to cancel.

Optional Feature:
- FETCHQ_BYPASS_EN defined:
  - When drop_cnt==0, fill_ptr==head_ptr, used>0 and rsp_valid, the queue presents rsp_data on dec_instr combinationally with dec_valid=1.
  - If dec_ready, the entry is popped without being marked filled.
  - Gives 0-cycle fill-to-decode latency.
- Undefined: strictly registered path as above (1-cycle latency).

Decomposition:
- Package fetch_pkg:
  - typedef fq_entry_t {pc, instr, filled}
  - constant NOP_INSTR = 32'h0000_0013
  - ILEN = 32
- No sub-module: pointer arithmetic is small enough to stay inline.

Test Plan:
- Reset, pc_in=0x8000_0000, req_ready=1, 1-cycle memory returning 0xAAAA_0000+n → dec_pc sequence 0x8000_0000, 0x8000_0004…; one instr/cycle after fill; dec_instr matches.
- dec_ready=0 for 10 cycles → exactly DEPTH=4 requests issued; pc_stll=1 once full; no entry overwritten; drain order is correct.
- 3 requests outstanding, flush with pc_in=0x8000_0100 → 3 old responses discarded; first dec_pc=0x8000_0100.
- Flush in the same cycle as rsp_valid with 1 outstanding → that response dropped; drop_cnt=0 afterwards; no stale dec_valid.
- req_ready toggling every other cycle, dec_ready random → no PC skip or duplicate; pc_inc count == pops + occupancy.
- Reset asserted with 2 entries filled and dec_valid=1 → next cycle dec_valid=0, dec_instr=0x0000_0013, pc_stll=1.
